// File: rtl/vid_fb_pkg.sv
// Shared constants and FSM encoding for the framebuffer scanout engine.
package vid_fb_pkg;

    localparam int unsigned FB_AW      = 14;
    localparam int unsigned FB_DW      = 32;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_LW    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

endpackage

// File: rtl/vid_fb_scanout_fifo.sv
// Small synchronous FIFO holding pixel words plus their end-of-line tag.
// flush has priority over push and pop in the same cycle.
module vid_fb_scanout_fifo
    import vid_fb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [FB_DW:0]     wdata,
    output logic [FB_DW:0]     rdata,
    output logic               full,
    output logic               empty,
    output logic [FIFO_LW-1:0] level
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [FB_DW:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [FIFO_LW-1:0] cnt_q;
    logic               do_push;
    logic               do_pop;

    always_comb begin
        full    = (cnt_q == FIFO_LW'(FIFO_DEPTH));
        empty   = (cnt_q == '0);
        level   = cnt_q;
        do_push = push && !full;
        do_pop  = pop && !empty;
        rdata   = mem_q[rd_ptr_q];
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + FIFO_LW'(1);
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - FIFO_LW'(1);
            end
        end
    end

endmodule

// File: rtl/vid_fb_scanout.sv
// Framebuffer scanout: fetches a frame line by line into a 4-entry FIFO and streams pixels.
// Define VID_FB_SCANOUT_LINEDBL_EN to fetch every framebuffer line twice (line doubling).
module vid_fb_scanout
    import vid_fb_pkg::*;
#(
    parameter int unsigned      H_WORDS   = 80,
    parameter int unsigned      V_LINES   = 200,
    parameter logic [FB_AW-1:0] BASE_ADDR = 14'h0000,
    parameter int unsigned      MAX_BURST = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    output logic [FB_AW-1:0] v_addr_0,
    output logic             v_re_0,
    input  logic [FB_DW-1:0] v_data_1,
    output logic [FB_DW-1:0] px_data,
    output logic             px_valid,
    input  logic             px_ready,
    output logic             px_last,
    output logic             busy,
    output logic             underrun
);

    localparam int unsigned      WW          = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
    localparam int unsigned      LW          = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int unsigned      BW          = $clog2(MAX_BURST + 1);
    localparam logic [WW-1:0]    LAST_WORD   = WW'(H_WORDS - 1);
    localparam logic [LW-1:0]    LAST_LINE   = LW'(V_LINES - 1);
    localparam logic [FB_AW-1:0] LINE_STRIDE = FB_AW'(H_WORDS);

    state_e             state_q;
    logic [WW-1:0]      word_q;
    logic [LW-1:0]      line_q;
    logic [FB_AW-1:0]   line_base_q;
    logic [BW-1:0]      burst_q;
    logic               inflight_q;
    logic               inflight_last_q;
`ifdef VID_FB_SCANOUT_LINEDBL_EN
    logic               pass_q;
`endif

    logic [FB_DW:0]     fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FIFO_LW-1:0] fifo_level;
    logic               fifo_pop;
    logic [FIFO_LW:0]   occupancy;
    logic               word_end;
    logic               line_end;
    logic               frame_end;
    logic               drain_done;

    always_comb begin
        occupancy = {1'b0, fifo_level} + {{FIFO_LW{1'b0}}, inflight_q};
        v_re_0    = (state_q == ST_ACTIVE) && !fifo_full
                    && (occupancy < (FIFO_LW + 1)'(FIFO_DEPTH))
                    && (burst_q < BW'(MAX_BURST));
        v_addr_0  = line_base_q + FB_AW'(word_q);
        word_end  = (word_q == LAST_WORD);
`ifdef VID_FB_SCANOUT_LINEDBL_EN
        line_end  = word_end && pass_q;
`else
        line_end  = word_end;
`endif
        frame_end = line_end && (line_q == LAST_LINE);

        px_valid  = !fifo_empty;
        px_data   = fifo_empty ? '0 : fifo_rdata[FB_DW-1:0];
        px_last   = !fifo_empty && fifo_rdata[FB_DW];
        // A restart flushes the FIFO, so a coincident handshake is discarded.
        fifo_pop  = px_valid && px_ready && !frame_start;

        // Leave DRAIN on the cycle the final word is accepted.
        drain_done = !inflight_q
                     && (fifo_empty || ((fifo_level == FIFO_LW'(1)) && fifo_pop));

        busy      = (state_q != ST_IDLE);
        underrun  = busy && px_ready && !px_valid;
    end

    vid_fb_scanout_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (frame_start),
        .push  (inflight_q),
        .pop   (fifo_pop),
        .wdata ({inflight_last_q, v_data_1}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            word_q          <= '0;
            line_q          <= '0;
            line_base_q     <= BASE_ADDR;
            burst_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
`ifdef VID_FB_SCANOUT_LINEDBL_EN
            pass_q          <= 1'b0;
`endif
        end else begin
            // Read data issued alongside a restart belongs to the old frame.
            inflight_q      <= v_re_0 && !frame_start;
            inflight_last_q <= word_end;
            burst_q         <= v_re_0 ? burst_q + BW'(1) : '0;

            if (frame_start) begin
                state_q     <= ST_ACTIVE;
                word_q      <= '0;
                line_q      <= '0;
                line_base_q <= BASE_ADDR;
`ifdef VID_FB_SCANOUT_LINEDBL_EN
                pass_q      <= 1'b0;
`endif
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_ACTIVE: begin
                        if (v_re_0) begin
                            if (word_end) begin
                                word_q <= '0;
`ifdef VID_FB_SCANOUT_LINEDBL_EN
                                pass_q <= !pass_q;
                                if (pass_q) begin
                                    line_q      <= line_q + LW'(1);
                                    line_base_q <= line_base_q + LINE_STRIDE;
                                end
`else
                                line_q      <= line_q + LW'(1);
                                line_base_q <= line_base_q + LINE_STRIDE;
`endif
                            end else begin
                                word_q <= word_q + WW'(1);
                            end
                            if (frame_end) begin
                                state_q <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_done) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vid_fb_scanout.sv
// Self-checking bench: three scanout instances (plain, 14-bit address wrap, short lines)
// share stimulus and are checked against a frame-order reference model.
module tb_vid_fb_scanout;

`ifdef VID_FB_SCANOUT_LINEDBL_EN
    localparam int DBL = 2;
`else
    localparam int DBL = 1;
`endif
    localparam int MAXB = 3;
    localparam int NI   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        px_ready;
    logic [13:0] v_addr   [NI];
    logic        v_re     [NI];
    logic [31:0] v_data   [NI];
    logic [31:0] px_data  [NI];
    logic        px_valid [NI];
    logic        px_last  [NI];
    logic        busy     [NI];
    logic        underrun [NI];

    int total = 0;
    int bad   = 0;

    // Reference model state per instance.
    int          rd_n      [NI];
    int          acc_n     [NI];
    int          run_n     [NI];
    bit          started   [NI];
    bit          hold      [NI];
    logic [31:0] hold_data [NI];
    logic        hold_last [NI];

    always #5 clk = ~clk;

    vid_fb_scanout #(.H_WORDS(4), .V_LINES(2), .BASE_ADDR(14'h0010), .MAX_BURST(MAXB)) u_dut0 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .v_addr_0(v_addr[0]), .v_re_0(v_re[0]),
        .v_data_1(v_data[0]), .px_data(px_data[0]), .px_valid(px_valid[0]), .px_ready(px_ready),
        .px_last(px_last[0]), .busy(busy[0]), .underrun(underrun[0])
    );
    vid_fb_scanout #(.H_WORDS(4), .V_LINES(2), .BASE_ADDR(14'h3FFE), .MAX_BURST(MAXB)) u_dut1 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .v_addr_0(v_addr[1]), .v_re_0(v_re[1]),
        .v_data_1(v_data[1]), .px_data(px_data[1]), .px_valid(px_valid[1]), .px_ready(px_ready),
        .px_last(px_last[1]), .busy(busy[1]), .underrun(underrun[1])
    );
    vid_fb_scanout #(.H_WORDS(2), .V_LINES(2), .BASE_ADDR(14'h0000), .MAX_BURST(MAXB)) u_dut2 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .v_addr_0(v_addr[2]), .v_re_0(v_re[2]),
        .v_data_1(v_data[2]), .px_data(px_data[2]), .px_valid(px_valid[2]), .px_ready(px_ready),
        .px_last(px_last[2]), .busy(busy[2]), .underrun(underrun[2])
    );

    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return {a ^ 14'h2AAA, 4'h5, a};
    endfunction

    // Framebuffer: read data appears the cycle after the address.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            v_data[i] <= mem_word(v_addr[i]);
        end
    end

    function automatic int hw(input int i);
        return (i == 2) ? 2 : 4;
    endfunction

    function automatic int base(input int i);
        return (i == 0) ? 'h10 : ((i == 1) ? 'h3FFE : 0);
    endfunction

    function automatic int nwords(input int i);
        return hw(i) * 2 * DBL;
    endfunction

    // Address of the n-th word of the output stream.
    function automatic logic [13:0] exp_addr(input int i, input int n);
        int out_line;
        int fb_line;
        int w;
        out_line = n / hw(i);
        w        = n % hw(i);
        fb_line  = out_line / DBL;
        return 14'((base(i) + fb_line * hw(i) + w) % 16384);
    endfunction

    task automatic chk_w(input string name, input int i, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string name, input int i, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0b want %0b at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic exp_busy;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                started[i] = 1'b0;
                rd_n[i]    = 0;
                acc_n[i]   = 0;
                run_n[i]   = 0;
                hold[i]    = 1'b0;
                continue;
            end
            exp_busy = started[i] && (acc_n[i] < nwords(i));
            chk_b("busy", i, busy[i], exp_busy);
            chk_b("underrun", i, underrun[i], exp_busy && px_ready && !px_valid[i]);
            if (hold[i]) begin
                chk_b("hold_valid", i, px_valid[i], 1'b1);
                chk_w("hold_data", i, px_data[i], hold_data[i]);
                chk_b("hold_last", i, px_last[i], hold_last[i]);
            end
            run_n[i] = v_re[i] ? run_n[i] + 1 : 0;
            if (v_re[i]) chk_b("burst_len", i, run_n[i] <= MAXB, 1'b1);
            if (frame_start) begin
                started[i] = 1'b1;
                rd_n[i]    = 0;
                acc_n[i]   = 0;
                hold[i]    = 1'b0;
                continue;
            end
            if (v_re[i]) begin
                chk_b("read_allowed", i, started[i] && (rd_n[i] < nwords(i)), 1'b1);
                if (rd_n[i] < nwords(i)) chk_w("rd_addr", i, 32'(v_addr[i]),
                                                32'(exp_addr(i, rd_n[i])));
                rd_n[i]++;
                chk_b("occupancy", i, (rd_n[i] - acc_n[i]) <= 4, 1'b1);
            end
            if (px_valid[i] && px_ready) begin
                chk_b("accept_allowed", i, started[i] && (acc_n[i] < rd_n[i]), 1'b1);
                if (acc_n[i] < nwords(i)) begin
                    chk_w("px_data", i, px_data[i], mem_word(exp_addr(i, acc_n[i])));
                    chk_b("px_last", i, px_last[i], (acc_n[i] % hw(i)) == hw(i) - 1);
                end
                acc_n[i]++;
            end
            hold[i]      = px_valid[i] && !px_ready;
            hold_data[i] = px_data[i];
            hold_last[i] = px_last[i];
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input int i);
        chk_b("rst_re", i, v_re[i], 1'b0);
        chk_w("rst_addr", i, 32'(v_addr[i]), 32'(base(i)));
        chk_b("rst_valid", i, px_valid[i], 1'b0);
        chk_w("rst_data", i, px_data[i], 32'h0);
        chk_b("rst_last", i, px_last[i], 1'b0);
        chk_b("rst_busy", i, busy[i], 1'b0);
        chk_b("rst_underrun", i, underrun[i], 1'b0);
    endtask

    function automatic bit all_done();
        for (int i = 0; i < NI; i++) begin
            if (acc_n[i] < nwords(i)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // mode 0: px_ready held high; mode 1: random back-pressure.
    task automatic wait_done(input int mode);
        int budget;
        budget = 3000;
        while (!all_done() && budget > 0) begin
            px_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            cyc();
            adv();
            budget--;
        end
        for (int i = 0; i < NI; i++) chk_w("frame_done", i, acc_n[i], nwords(i));
        px_ready = 1'b1;
        repeat (2) begin
            cyc();
            adv();
        end
    endtask

    task automatic wait_acc(input int k);
        int budget;
        budget = 200;
        while (acc_n[0] < k && budget > 0) begin
            cyc();
            adv();
            budget--;
        end
        chk_w("reach_acc", 0, acc_n[0], k);
    endtask

    task automatic start_frame(input logic rdy);
        frame_start = 1'b1;
        px_ready    = rdy;
        cyc();
        adv();
        frame_start = 1'b0;
    endtask

    typedef struct {
        bit          fs;
        bit          rdy;
        bit          re;
        logic [13:0] addr;
        bit          valid;
        logic [13:0] daddr;
        bit          last;
        bit          bsy;
        bit          und;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // First frame of instance 0 with px_ready high, cycle by cycle from frame_start.
        tbl[0]  = '{1, 1, 0, 14'h00, 0, 14'h00, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 14'h10, 0, 14'h00, 0, 1, 1};
        tbl[2]  = '{0, 1, 1, 14'h11, 0, 14'h00, 0, 1, 1};
        tbl[3]  = '{0, 1, 1, 14'h12, 1, 14'h10, 0, 1, 0};
        tbl[4]  = '{0, 1, 0, 14'h00, 1, 14'h11, 0, 1, 0};
        tbl[5]  = '{0, 1, 1, 14'h13, 1, 14'h12, 0, 1, 0};
        tbl[6]  = '{0, 1, 1, 14'h14, 0, 14'h00, 0, 1, 1};
        tbl[7]  = '{0, 1, 1, 14'h15, 1, 14'h13, 1, 1, 0};
        tbl[8]  = '{0, 1, 0, 14'h00, 1, 14'h14, 0, 1, 0};
        tbl[9]  = '{0, 1, 1, 14'h16, 1, 14'h15, 0, 1, 0};
        tbl[10] = '{0, 1, 1, 14'h17, 0, 14'h00, 0, 1, 1};
        tbl[11] = '{0, 1, 0, 14'h00, 1, 14'h16, 0, 1, 0};
        tbl[12] = '{0, 1, 0, 14'h00, 1, 14'h17, 1, 1, 0};
        tbl[13] = '{0, 1, 0, 14'h00, 0, 14'h00, 0, 0, 0};

        rst         = 1'b1;
        frame_start = 1'b0;
        px_ready    = 1'b0;
        repeat (2) adv();
        cyc();
        for (int i = 0; i < NI; i++) check_reset(i);
        adv();
        rst = 1'b0;
        cyc();
        adv();

`ifndef VID_FB_SCANOUT_LINEDBL_EN
        for (int k = 0; k < 14; k++) begin
            frame_start = tbl[k].fs;
            px_ready    = tbl[k].rdy;
            cyc();
            chk_b("tbl_re", k, v_re[0], tbl[k].re);
            if (tbl[k].re) chk_w("tbl_addr", k, 32'(v_addr[0]), 32'(tbl[k].addr));
            chk_b("tbl_valid", k, px_valid[0], tbl[k].valid);
            if (tbl[k].valid) begin
                chk_w("tbl_data", k, px_data[0], mem_word(tbl[k].daddr));
                chk_b("tbl_last", k, px_last[0], tbl[k].last);
            end
            chk_b("tbl_busy", k, busy[0], tbl[k].bsy);
            chk_b("tbl_underrun", k, underrun[0], tbl[k].und);
            adv();
        end
        frame_start = 1'b0;
        wait_done(0);
`else
        start_frame(1'b1);
        wait_done(0);
`endif

        // Random back-pressure frames.
        for (int f = 0; f < 3; f++) begin
            start_frame(1'($urandom_range(0, 1)));
            wait_done(1);
        end

        // Consumer stalled: fetch must stop once FIFO plus in-flight reach four.
        start_frame(1'b0);
        repeat (20) begin
            px_ready = 1'b0;
            cyc();
            adv();
        end
        for (int i = 0; i < NI; i++) chk_w("stall_reads", i, rd_n[i], 4);
        wait_done(0);

        // Restart after five accepted words.
        start_frame(1'b1);
        wait_acc(5);
        start_frame(1'b1);
        wait_done(0);

        // Reset at the same point of a frame.
        start_frame(1'b1);
        wait_acc(5);
        rst = 1'b1;
        cyc();
        for (int i = 0; i < NI; i++) check_reset(i);
        adv();
        rst = 1'b0;
        repeat (4) begin
            cyc();
            adv();
        end
        start_frame(1'b1);
        wait_done(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vid_fb_scanout.md
VID_FB_SCANOUT -- requirements
Module: vid_fb_scanout

Interface
REQ-001 SHALL have parameter H_WORDS, default 80: 32-bit framebuffer words per line.
REQ-002 SHALL have parameter V_LINES, default 200: lines per frame.
REQ-003 SHALL have parameter BASE_ADDR, default 14'h0000: word address of line 0, word 0.
REQ-004 SHALL have parameter MAX_BURST, default 3: maximum number of consecutive read cycles before a mandatory idle cycle.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port frame_start, input, 1: one-cycle pulse that starts a frame.
REQ-008 SHALL have port v_addr_0, output, 14: framebuffer read word address.
REQ-009 SHALL have port v_re_0, output, 1: framebuffer read strobe, which takes priority over the aux port.
REQ-010 SHALL have port v_data_1, input, 32: read data, valid the cycle after v_re_0.
REQ-011 SHALL have port px_data, output, 32: pixel word to the video encoder.
REQ-012 SHALL have port px_valid, output, 1: px_data is valid.
REQ-013 SHALL have port px_ready, input, 1: consumer accepts px_data when px_valid and px_ready are both high.
REQ-014 SHALL have port px_last, output, 1: px_data is the last word of a line.
REQ-015 SHALL have port busy, output, 1: frame fetch in progress.
REQ-016 SHALL have port underrun, output, 1: one-cycle pulse.

Function
REQ-017 SHALL be a 3-state FSM:
- IDLE, then ACTIVE on frame_start.
- ACTIVE, then DRAIN after the last read of the frame is issued.
- DRAIN, then IDLE when the FIFO is empty and no read is in flight.
REQ-018 SHALL hold a 4-entry FIFO and issue v_re_0 only in ACTIVE, and only when FIFO occupancy plus in-flight reads is less than 4.
REQ-019 SHALL write v_data_1 into the FIFO on the cycle after each v_re_0, unconditionally; space is guaranteed by REQ-018.
REQ-020 SHALL drive v_addr_0 as BASE_ADDR + line*H_WORDS + word, computed modulo 2^14 (wraps at 16384).
REQ-021 SHALL drive v_re_0 low for at least one cycle after MAX_BURST consecutive high cycles, so the aux port is guaranteed a slot.
REQ-022 SHALL have a latency of 2 cycles from the first v_re_0 of a frame to px_valid, with px_ready held high.
REQ-023 SHALL increment word on each read, wrap word from H_WORDS-1 to 0, and increment line on that wrap.
REQ-024 SHALL assert px_last together with the FIFO entry whose word index was H_WORDS-1; the tag is stored in the FIFO.
REQ-025 SHALL keep px_data and px_last stable while px_valid is high and px_ready is low.
REQ-026 SHALL pulse underrun for one cycle when px_ready is high and px_valid is low while busy is high.
REQ-027 SHALL treat frame_start in ACTIVE or DRAIN as a restart:
- flush the FIFO and discard any in-flight read data;
- line=0, word=0; state ACTIVE.
REQ-028 SHALL give frame_start priority over a simultaneous FIFO pop, and SHALL drop that pop.
REQ-029 SHALL assert busy in ACTIVE and DRAIN.

Reset
REQ-030 SHALL set the following while rst is high:
- state IDLE, FIFO empty, in-flight count 0, line=0, word=0;
- v_re_0=0, v_addr_0=BASE_ADDR;
- px_valid=0, px_data=0, px_last=0, busy=0, underrun=0.
REQ-031 SHALL, on rst asserted mid-frame, abort the frame immediately and ignore v_data_1 on the following cycle.

Configuration
REQ-032 SHALL implement line doubling when VID_FB_SCANOUT_LINEDBL_EN is defined:
- each line is fetched twice;
- the frame produces 2*V_LINES output lines from V_LINES framebuffer lines.
REQ-033 SHALL, without VID_FB_SCANOUT_LINEDBL_EN, fetch each line exactly once and contain no line-doubling logic.

Structure
REQ-034 SHALL take its constants from shared package vid_fb_pkg:
- FB_AW=14, FB_DW=32;
- FSM state encoding (ST_IDLE, ST_ACTIVE, ST_DRAIN);
- FIFO_DEPTH=4.
REQ-035 SHALL instantiate the FIFO as sub-module vid_fb_scanout_fifo:
- synchronous, 4 x 33 bits (data plus last tag);
- ports push, pop, flush, full, empty and level.

Verification
REQ-036 SHALL cover: H_WORDS=4, V_LINES=2, BASE_ADDR=0x10, px_ready=1, frame_start -> addresses 0x10..0x17 in order; px_last on the 4th and 8th words; busy falls after the 8th accept.
REQ-037 SHALL cover: MAX_BURST=3, px_ready=1 -> no run of more than 3 consecutive v_re_0 high cycles; after each such run v_re_0=0 for at least 1 cycle.
REQ-038 SHALL cover: px_ready=0 for 20 cycles -> exactly 4 reads issued, px_data stable; on release, data is in order with no loss.
REQ-039 SHALL cover: BASE_ADDR=0x3FFE, H_WORDS=4 -> v_addr_0 sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001.
REQ-040 SHALL cover: frame_start reasserted after 5 words accepted -> FIFO flushed and the next px_data is word 0 of line 0; rst at the same point -> all outputs return to reset values.
REQ-041 SHALL cover: with VID_FB_SCANOUT_LINEDBL_EN defined, H_WORDS=2, V_LINES=2 -> address sequence 0, 1, 0, 1, 2, 3, 2, 3 with 4 px_last pulses.
